wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter that drives the single write port of the core register file. It merges two sources. The first is in-order pipeline results, which never stall. The second is long-latency results (loads, multiplier), which are buffered in a small FIFO. It also keeps a pending-destination scoreboard so the hazard logic can stall readers of registers still awaiting a late result. All register-file write outputs are registered at posedge, so they are stable for the register file's negedge write.

## Interface
- DEPTH, 4, late-result FIFO entries; power of two, ≥2
- XLEN, 32, data width
- clk  in  1  clock, posedge
- rst  in  1  reset, synchronous, active-high
- pipe_valid  in  1  pipeline result valid this cycle; no backpressure
- pipe_rd  in  5  pipeline destination
- pipe_data  in  XLEN  pipeline result
- late_valid  in  1  late result offered
- late_ready  out  1  late result accepted when late_valid & late_ready
- late_rd  in  5  late destination
- late_data  in  XLEN  late result
- mark_valid  in  1  issue of a long-latency op; sets pending bit
- mark_rd  in  5  destination of that op
- rs1, rs2  in  5 each  source registers of the instruction in decode
- stall  out  1  pending[rs1] | pending[rs2], combinational
- rf_write_en  out  1  register-file write enable, registered
- rf_rd  out  5  register-file destination, registered
- rf_write_data  out  XLEN  register-file data, registered
- pending  out  32  scoreboard vector; bit 0 is always 0

## Operation
- **Priority:** the pipeline write always wins the output register. FIFO drains only in cycles with pipe_valid=0.
- **Pipeline writes:**
  - pipe_valid with pipe_rd≠0 loads the output register with {1, pipe_rd, pipe_data}.
  - pipe_rd=0 produces rf_write_en=0.
- **Late accept:**
  - late_ready = (count < DEPTH) & !rst.
  - An accepted late write with late_rd≠0 is pushed into the FIFO.
  - An accepted late write with late_rd=0 is accepted and discarded.
- **Drain:** when pipe_valid=0 and the FIFO is non-empty, the head is popped into the output register.
- **Idle:** otherwise the output register gets rf_write_en=0. rf_rd and rf_write_data hold their previous values.
- **Push and pop together:** allowed in the same cycle, count unchanged. late_ready is computed from the pre-edge count, so a full FIFO does not accept in the cycle it pops.
- **FIFO pointers:** wrap modulo DEPTH; count ranges 0..DEPTH.
- **Scoreboard:**
  - mark_valid with mark_rd≠0 sets pending[mark_rd] at the edge.
  - A late entry being loaded into the output register clears pending[its rd] at the same edge.
  - If set and clear hit the same rd in the same cycle, set wins.
- **WAW hazards:** a pipeline write to a pending rd does not clear the pending bit. Preventing WAW is the hazard unit's job.

## Timing
- **Reset:** with rst high at an edge:
  - FIFO is emptied, count=0, pending=0.
  - rf_write_en=0, rf_rd=0, rf_write_data=0.
  - late_ready=0 while rst is high and 1 in the first cycle after.
- **Reset mid-operation:** buffered late writes are dropped. No write is emitted in the cycle after reset.
- **Pipeline latency:** pipe_valid at cycle N gives rf_write_en high in N+1, for exactly one cycle per result.
- **Late latency, baseline:** accepted at N, popped at N+1 at the earliest, rf_write_en in N+2.
- **Late latency, bypass build:** see Configuration.
- **Order:** late writes leave in acceptance order. Pipeline writes leave in issue order. Each accepted late write (rd≠0) is emitted exactly once.
- **stall:** follows pending, which updates at the edge. A mark at N raises stall for a matching rs from N+1.

## Configuration
- **Macro:** WB_BYPASS_EN.
- **Defined:** if the FIFO is empty, pipe_valid=0 and a late write with rd≠0 is accepted at cycle N, it goes directly into the output register (rf_write_en at N+1) and is not pushed. It clears its pending bit at that edge.
- **Undefined:** every late write passes through the FIFO; minimum late latency is 2 cycles.

## Test plan
- **Reset:** rst for 2 cycles with late_valid=1 -> late_ready=0 during reset; all outputs 0; pending=0 afterwards.
- **Pipeline only:** pipe writes rd=5/0xAAAA_0001 at N, rd=0 at N+1 -> rf_write_en=1, rf_rd=5, rf_write_data=0xAAAA_0001 at N+1; rf_write_en=0 at N+2.
- **Conflict:**
  - Stimulus: mark rd=7; late rd=7/0x1234 accepted at N; pipe_valid held 1 for cycles N..N+3.
  - Required: no late write while pipe_valid is held; rf_rd=7 with 0x1234 at N+5.
  - Required: stall with rs1=7 stays 1 through N+4 and falls at N+5.
- **Full FIFO (DEPTH=4):** pipe_valid held, 5 late offers -> late_ready=0 on the 5th. Release pipe -> writes emitted in order 1..4, one per cycle.
- **Set/clear collision:** pending rd=9 clears and mark rd=9 arrives in the same cycle -> pending[9] remains 1. rd=0 late write -> accepted, never emitted.
- **Bypass:** empty FIFO, late rd=3/0xBEEF at N -> with WB_BYPASS_EN, write at N+1; without it, write at N+2.

Source files
------------

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//
// Drives the single write port of the core register file from two sources:
//   * in-order pipeline results (never stall, always win the write port)
//   * long-latency results (loads, multiplier), buffered in a small FIFO and
//     drained only in cycles where the pipeline is not writing.
// A pending-destination scoreboard marks registers awaiting a late result so
// the hazard logic can stall readers of those registers.
//
// All register-file write outputs are registered at posedge, so they are
// stable for the register file's negedge write.
//
// Optional feature macro: WB_BYPASS_EN
//   defined   - a late write arriving with an empty FIFO and no pipeline write
//               goes straight into the output register (one cycle earlier).
//   undefined - every late write passes through the FIFO.
//
// Parameters:
//   DEPTH  late-result FIFO entries (power of two, >= 2)
//   XLEN   data width
//
// Ports:
//   clk, rst                 clock (posedge), synchronous active-high reset
//   pipe_valid/rd/data       pipeline result, no backpressure
//   late_valid/ready/rd/data late result handshake
//   mark_valid/mark_rd       long-latency issue, sets pending[mark_rd]
//   rs1, rs2                 decode source registers
//   stall                    pending[rs1] | pending[rs2] (combinational)
//   rf_write_en/rd/data      registered register-file write port
//   pending                  scoreboard vector, bit 0 always 0
// -----------------------------------------------------------------------------
module wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pipe_valid,
    input  logic [4:0]      pipe_rd,
    input  logic [XLEN-1:0] pipe_data,
    input  logic            late_valid,
    output logic            late_ready,
    input  logic [4:0]      late_rd,
    input  logic [XLEN-1:0] late_data,
    input  logic            mark_valid,
    input  logic [4:0]      mark_rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            stall,
    output logic            rf_write_en,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_write_data,
    output logic [31:0]     pending
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [4:0]      fifo_rd_r   [DEPTH];
    logic [XLEN-1:0] fifo_data_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [31:0]      pending_r;

    logic             accept_s;
    logic             push_s;
    logic             pop_s;
    logic             bypass_s;
    logic             fifo_empty_s;
    logic [4:0]       head_rd_s;
    logic [XLEN-1:0]  head_data_s;
    logic [31:0]      set_vec_s;
    logic [31:0]      clr_vec_s;

    // late_ready uses the pre-edge count, so a full FIFO never accepts in
    // the same cycle it pops.
    assign late_ready   = (count_r < DEPTH_C) & ~rst;
    assign accept_s     = late_valid & late_ready;
    assign fifo_empty_s = (count_r == {CNT_W{1'b0}});
    assign head_rd_s    = fifo_rd_r[rd_ptr_r];
    assign head_data_s  = fifo_data_r[rd_ptr_r];
    assign pending      = pending_r;
    assign stall        = pending_r[rs1] | pending_r[rs2];

    // Decide bypass / push / pop for this cycle.
    always_comb begin
        bypass_s = 1'b0;
`ifdef WB_BYPASS_EN
        bypass_s = accept_s & (late_rd != 5'd0) & ~pipe_valid & fifo_empty_s;
`else
        bypass_s = 1'b0;
`endif
        // rd=0 late writes are accepted but never stored.
        push_s = accept_s & (late_rd != 5'd0) & ~bypass_s;
        pop_s  = ~pipe_valid & ~fifo_empty_s;
    end

    // FIFO storage; contents need no reset because count gates validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_rd_r[wr_ptr_r]   <= late_rd;
            fifo_data_r[wr_ptr_r] <= late_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Scoreboard set/clear vectors: clear follows whichever late entry is
    // being loaded into the output register this cycle.
    always_comb begin
        set_vec_s = 32'd0;
        clr_vec_s = 32'd0;
        if (mark_valid) begin
            set_vec_s[mark_rd] = 1'b1;
        end else begin
            set_vec_s = 32'd0;
        end
        if (pop_s) begin
            clr_vec_s[head_rd_s] = 1'b1;
        end else if (bypass_s) begin
            clr_vec_s[late_rd] = 1'b1;
        end else begin
            clr_vec_s = 32'd0;
        end
    end

    // Scoreboard register: set wins over clear; bit 0 is hardwired to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= 32'd0;
        end else begin
            pending_r <= ((pending_r & ~clr_vec_s) | set_vec_s) & ~32'd1;
        end
    end

    // Register-file write port: pipeline > FIFO head > bypass > idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_write_en   <= 1'b0;
            rf_rd         <= 5'd0;
            rf_write_data <= {XLEN{1'b0}};
        end else if (pipe_valid) begin
            // A pipeline result to x0 occupies the slot but writes nothing.
            rf_write_en <= (pipe_rd != 5'd0);
            if (pipe_rd != 5'd0) begin
                rf_rd         <= pipe_rd;
                rf_write_data <= pipe_data;
            end
        end else if (pop_s) begin
            rf_write_en   <= 1'b1;
            rf_rd         <= head_rd_s;
            rf_write_data <= head_data_s;
        end else if (bypass_s) begin
            rf_write_en   <= 1'b1;
            rf_rd         <= late_rd;
            rf_write_data <= late_data;
        end else begin
            rf_write_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
//
// Directed self-checking bench for wb_arbiter (DEPTH=4, XLEN=32). Inputs are
// driven 1 time unit after each posedge; outputs are sampled at that point,
// i.e. they reflect the edge just taken. Expected values are hand-computed.
// Honors WB_BYPASS_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        late_valid;
    logic        late_ready;
    logic [4:0]  late_rd;
    logic [31:0] late_data;
    logic        mark_valid;
    logic [4:0]  mark_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        stall;
    logic        rf_write_en;
    logic [4:0]  rf_rd;
    logic [31:0] rf_write_data;
    logic [31:0] pending;

    int checks;
    int failures;

    wb_arbiter #(.DEPTH(4), .XLEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .pipe_valid    (pipe_valid),
        .pipe_rd       (pipe_rd),
        .pipe_data     (pipe_data),
        .late_valid    (late_valid),
        .late_ready    (late_ready),
        .late_rd       (late_rd),
        .late_data     (late_data),
        .mark_valid    (mark_valid),
        .mark_rd       (mark_rd),
        .rs1           (rs1),
        .rs2           (rs2),
        .stall         (stall),
        .rf_write_en   (rf_write_en),
        .rf_rd         (rf_rd),
        .rf_write_data (rf_write_data),
        .pending       (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        late_valid = 1'b1;
        late_rd = 5'd4;
        late_data = 32'h4444_0000;
        #1;
        checks++;
        if (late_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_low got=%b exp=0", late_ready);
        end
        tick();
        tick();
        checks++;
        if (late_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_low2 got=%b exp=0", late_ready);
        end
        checks++;
        if (rf_write_en !== 1'b0 || rf_rd !== 5'd0 || rf_write_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b/%0d/%h exp=0/0/0", rf_write_en, rf_rd, rf_write_data);
        end
        checks++;
        if (pending !== 32'd0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_pending got=%h stall=%b exp=0", pending, stall);
        end
        rst = 1'b0;
        late_valid = 1'b0;
        #1;
        checks++;
        if (late_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_ready got=%b exp=1", late_ready);
        end
        tick();
        checks++;
        if (rf_write_en !== 1'b0 || pending !== 32'd0) begin
            failures++;
            $display("FAIL post_reset_idle got=%b pend=%h exp=0/0", rf_write_en, pending);
        end
    endtask

    task automatic test_pipeline();
        pipe_valid = 1'b1;
        pipe_rd = 5'd5;
        pipe_data = 32'hAAAA_0001;
        tick();
        checks++;
        if (rf_write_en !== 1'b1 || rf_rd !== 5'd5 || rf_write_data !== 32'hAAAA_0001) begin
            failures++;
            $display("FAIL pipe_write got=%b/%0d/%h exp=1/5/aaaa0001", rf_write_en, rf_rd, rf_write_data);
        end
        pipe_rd = 5'd0;
        pipe_data = 32'h5555_5555;
        tick();
        checks++;
        if (rf_write_en !== 1'b0) begin
            failures++;
            $display("FAIL pipe_rd0 got=%b exp=0", rf_write_en);
        end
        pipe_valid = 1'b0;
        tick();
        checks++;
        if (rf_write_en !== 1'b0) begin
            failures++;
            $display("FAIL pipe_idle got=%b exp=0", rf_write_en);
        end
    endtask

    task automatic test_conflict();
        rs1 = 5'd7;
        mark_valid = 1'b1;
        mark_rd = 5'd7;
        tick();
        mark_valid = 1'b0;
        // cycle N: late accepted while pipeline writes
        late_valid = 1'b1;
        late_rd = 5'd7;
        late_data = 32'h0000_1234;
        pipe_valid = 1'b1;
        pipe_rd = 5'd10;
        pipe_data = 32'hD000_0010;
        #1;
        checks++;
        if (late_ready !== 1'b1 || stall !== 1'b1) begin
            failures++;
            $display("FAIL conflict_accept ready=%b stall=%b exp=1/1", late_ready, stall);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            late_valid = 1'b0;
            checks++;
            if (rf_write_en !== 1'b1 || rf_rd !== 5'(10 + i) || rf_write_data !== 32'hD000_0010 + 32'(i)) begin
                failures++;
                $display("FAIL conflict_pipe_%0d got=%b/%0d/%h exp=1/%0d", i, rf_write_en, rf_rd, rf_write_data, 10 + i);
            end
            checks++;
            if (stall !== 1'b1) begin
                failures++;
                $display("FAIL conflict_stall_%0d got=%b exp=1", i, stall);
            end
            if (i < 3) begin
                pipe_rd = 5'(11 + i);
                pipe_data = 32'hD000_0011 + 32'(i);
            end else begin
                pipe_valid = 1'b0;
            end
        end
        // now at N+4: pipeline released, late write pops at this edge
        tick();
        checks++;
        if (rf_write_en !== 1'b1 || rf_rd !== 5'd7 || rf_write_data !== 32'h0000_1234) begin
            failures++;
            $display("FAIL conflict_late got=%b/%0d/%h exp=1/7/00001234", rf_write_en, rf_rd, rf_write_data);
        end
        checks++;
        if (stall !== 1'b0 || pending[7] !== 1'b0) begin
            failures++;
            $display("FAIL conflict_stall_fall got=%b exp=0", stall);
        end
        tick();
        checks++;
        if (rf_write_en !== 1'b0) begin
            failures++;
            $display("FAIL conflict_once got=%b exp=0", rf_write_en);
        end
        rs1 = 5'd0;
    endtask

    task automatic test_full_fifo();
        pipe_valid = 1'b1;
        pipe_rd = 5'd2;
        pipe_data = 32'h2222_2222;
        for (int i = 1; i <= 5; i++) begin
            late_valid = 1'b1;
            late_rd = 5'(i);
            late_data = 32'h100 + 32'(i);
            #1;
            checks++;
            if (late_ready !== (i <= 4)) begin
                failures++;
                $display("FAIL full_ready_%0d got=%b exp=%b", i, late_ready, (i <= 4));
            end
            tick();
        end
        late_valid = 1'b0;
        pipe_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (rf_write_en !== 1'b1 || rf_rd !== 5'(i) || rf_write_data !== 32'h100 + 32'(i)) begin
                failures++;
                $display("FAIL full_drain_%0d got=%b/%0d/%h exp=1/%0d", i, rf_write_en, rf_rd, rf_write_data, i);
            end
        end
        tick();
        checks++;
        if (rf_write_en !== 1'b0) begin
            failures++;
            $display("FAIL full_empty got=%b exp=0", rf_write_en);
        end
    endtask

    task automatic test_collision();
        mark_valid = 1'b1;
        mark_rd = 5'd9;
        tick();
        mark_valid = 1'b0;
        late_valid = 1'b1;
        late_rd = 5'd9;
        late_data = 32'h0000_0099;
`ifdef WB_BYPASS_EN
        // bypassed write clears at the acceptance edge; re-mark in same cycle
        mark_valid = 1'b1;
        tick();
        late_valid = 1'b0;
        mark_valid = 1'b0;
`else
        tick();
        late_valid = 1'b0;
        mark_valid = 1'b1;
        tick();
        mark_valid = 1'b0;
`endif
        checks++;
        if (rf_write_en !== 1'b1 || rf_rd !== 5'd9) begin
            failures++;
            $display("FAIL collision_write got=%b/%0d exp=1/9", rf_write_en, rf_rd);
        end
        checks++;
        if (pending[9] !== 1'b1) begin
            failures++;
            $display("FAIL collision_set_wins got=%b exp=1", pending[9]);
        end
        // rd=0 late write: accepted, never emitted, never marked
        late_valid = 1'b1;
        late_rd = 5'd0;
        late_data = 32'hDEAD_0000;
        mark_valid = 1'b1;
        mark_rd = 5'd0;
        #1;
        checks++;
        if (late_ready !== 1'b1) begin
            failures++;
            $display("FAIL rd0_ready got=%b exp=1", late_ready);
        end
        tick();
        late_valid = 1'b0;
        mark_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rf_write_en !== 1'b0 || pending[0] !== 1'b0) begin
                failures++;
                $display("FAIL rd0_dropped_%0d got=%b pend0=%b exp=0/0", i, rf_write_en, pending[0]);
            end
            tick();
        end
    endtask

    task automatic test_bypass();
        late_valid = 1'b1;
        late_rd = 5'd3;
        late_data = 32'h0000_BEEF;
        tick();
        late_valid = 1'b0;
`ifdef WB_BYPASS_EN
        checks++;
        if (rf_write_en !== 1'b1 || rf_rd !== 5'd3 || rf_write_data !== 32'h0000_BEEF) begin
            failures++;
            $display("FAIL bypass_n1 got=%b/%0d/%h exp=1/3/0000beef", rf_write_en, rf_rd, rf_write_data);
        end
        tick();
        checks++;
        if (rf_write_en !== 1'b0) begin
            failures++;
            $display("FAIL bypass_n2 got=%b exp=0", rf_write_en);
        end
`else
        checks++;
        if (rf_write_en !== 1'b0) begin
            failures++;
            $display("FAIL nobypass_n1 got=%b exp=0", rf_write_en);
        end
        tick();
        checks++;
        if (rf_write_en !== 1'b1 || rf_rd !== 5'd3 || rf_write_data !== 32'h0000_BEEF) begin
            failures++;
            $display("FAIL nobypass_n2 got=%b/%0d/%h exp=1/3/0000beef", rf_write_en, rf_rd, rf_write_data);
        end
`endif
        tick();
        checks++;
        if (rf_write_en !== 1'b0) begin
            failures++;
            $display("FAIL bypass_once got=%b exp=0", rf_write_en);
        end
    endtask

    task automatic test_reset_mid();
        mark_valid = 1'b1;
        mark_rd = 5'd12;
        pipe_valid = 1'b1;
        pipe_rd = 5'd2;
        late_valid = 1'b1;
        late_rd = 5'd6;
        tick();
        mark_valid = 1'b0;
        late_rd = 5'd8;
        tick();
        late_valid = 1'b0;
        pipe_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (pending !== 32'd0 || rf_write_en !== 1'b0 || rf_rd !== 5'd0) begin
            failures++;
            $display("FAIL midreset_clear pend=%h en=%b rd=%0d exp=0/0/0", pending, rf_write_en, rf_rd);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (rf_write_en !== 1'b0) begin
                failures++;
                $display("FAIL midreset_dropped_%0d got=%b exp=0", i, rf_write_en);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        pipe_valid = 1'b0;
        pipe_rd = 5'd0;
        pipe_data = 32'd0;
        late_valid = 1'b0;
        late_rd = 5'd0;
        late_data = 32'd0;
        mark_valid = 1'b0;
        mark_rd = 5'd0;
        rs1 = 5'd0;
        rs2 = 5'd0;
        test_reset();
        test_pipeline();
        test_conflict();
        test_full_fifo();
        test_collision();
        test_bypass();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
